ffsr_spike_ctrl: RTL and testbench
==================================

Name: ffsr_spike_ctrl

Overview:
Sequencer for a bank of NUM_CH ffsr_spike encoders. Accepts level commands on a valid/ready port and drives each encoder's rst/init/inc/dec pins, stepping every channel one level per cycle toward its target. Keeps a shadow level counter per channel, so downstream spike logic never reads the FFSR contents to learn its level. Sits between the neuron-input scheduler and the ffsr_spike instances.

Parameters:
- INPUT_SIZE, 16, FFSR width; levels range 0..INPUT_SIZE.
- NUM_CH, 4, number of ffsr_spike instances controlled.
- RST_CYCLES, 2, cycles ffsr rst is held during init or reload (minimum 1).
- LVL_W, $clog2(INPUT_SIZE+1), level width (5).
- CH_W, $clog2(NUM_CH) (minimum 1), channel-id width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge.
- cmd_op  in  2  00 SET, 01 RELOAD, 10 CLEAR_ALL, 11 NOP.
- cmd_ch  in  CH_W  target channel.
- cmd_level  in  LVL_W  level argument.
- ffsr_rst  out  NUM_CH  per-channel rst to ffsr_spike.
- ffsr_init  out  [0:INPUT_SIZE-1]  init bus shared by all channels.
- ffsr_inc  out  NUM_CH  per-channel inc.
- ffsr_dec  out  NUM_CH  per-channel dec.
- level  out  NUM_CH*LVL_W  shadow levels; channel c occupies bits [c*LVL_W +: LVL_W].
- settled  out  NUM_CH  per channel: (level==target) & ~inc & ~dec.

Behaviour:
- Outputs are registered. settled is combinational from registers only.
- Level encoding: L ones at the high-index end of ffsr_init, i.e. numeric value (1<<L)-1. L=4 gives 16'b0000000000001111.
- States are INIT, RUN and RELOAD.
- Reset (rst=1 at a posedge, at any time, including mid-RELOAD): state=INIT, cycle counter=0, all level=0, all target=0.
  - ffsr_rst=all ones, ffsr_init=0, inc=dec=0, cmd_ready=0.
- INIT: holds ffsr_rst high for RST_CYCLES cycles after rst deasserts, then goes to RUN with ffsr_rst=0 and cmd_ready=1.
- RUN: cmd_ready=1. Every cycle, for each channel c:
  - if level<target: inc=1, dec=0, level+1 on the same edge.
  - if level>target: dec=1, inc=0, level-1 on the same edge.
  - otherwise inc=dec=0.
  - inc and dec are never both high.
- Latency: SET accepted at edge E0 for distance d>0. The pulse is high for the d cycles following edges E1..Ed. settled rises after E(d+1). d=0: no pulse, and settled stays 1.
- SET: target[ch] = min(cmd_level, INPUT_SIZE). A new SET to a channel that is mid-step overrides the target. Stepping reverses direction on the next edge with no idle cycle.
- CLEAR_ALL: all targets=0. cmd_level and cmd_ch are ignored.
- NOP, or cmd_ch >= NUM_CH: accepted and no effect.
- RELOAD at E0: state=RELOAD, cmd_ready=0.
  - ffsr_rst[ch]=1 and ffsr_init=therm(min(cmd_level, INPUT_SIZE)) for RST_CYCLES cycles.
  - inc/dec of ch are forced to 0. Other channels keep stepping.
  - On exit: level[ch]=target[ch]=clamped level, ffsr_rst=0, back to RUN.
  - ffsr_init holds its last value outside RELOAD.
- Saturation: level never leaves 0..INPUT_SIZE. Clamping the target guarantees this.
- cmd_ready=0 in INIT and RELOAD. A command presented then is held by the requester and is not lost.

Test Plan:
1. rst high 2 cycles, then low -> ffsr_rst=4'b1111 for 2 cycles after release. Then cmd_ready=1, all level=0, settled=4'b1111.
2. SET ch1 level 3 -> ffsr_inc[1] high exactly 3 cycles, level[1]=3. settled[1] is low during the pulse and high after. Other channels are idle.
3. SET ch0 level 20 -> clamped: 16 inc pulses, level[0]=16. Then SET ch0 level 2 -> 14 dec pulses, level[0]=2.
4. SET ch2 level 10, then SET ch2 level 0 after 4 pulses -> level[2] goes 1..4, then reverses next cycle: 4 dec pulses to 0, no idle cycle.
5. RELOAD ch3 level 4 while ch1 is stepping -> ffsr_rst[3]=1 and ffsr_init=16'h000F for 2 cycles, with cmd_ready=0. ch1 keeps pulsing. After exit, level[3]=4 and settled[3]=1.
6. rst asserted mid-RELOAD -> next cycle all level=0, ffsr_rst=all ones, state INIT; the RELOAD is discarded.

Source files
------------

// File: rtl/ffsr_spike_ctrl.sv
// Level sequencer for a bank of ffsr_spike encoders: steps each channel one level per
// cycle toward its commanded target and keeps a shadow copy of every channel's level.
module ffsr_spike_ctrl #(
    parameter int INPUT_SIZE = 16,
    parameter int NUM_CH     = 4,
    parameter int RST_CYCLES = 2,
    parameter int LVL_W      = $clog2(INPUT_SIZE + 1),
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [CH_W-1:0]           cmd_ch,
    input  logic [LVL_W-1:0]          cmd_level,
    output logic [NUM_CH-1:0]         ffsr_rst,
    output logic [0:INPUT_SIZE-1]     ffsr_init,
    output logic [NUM_CH-1:0]         ffsr_inc,
    output logic [NUM_CH-1:0]         ffsr_dec,
    output logic [NUM_CH*LVL_W-1:0]   level,
    output logic [NUM_CH-1:0]         settled
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(INPUT_SIZE);

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_RELOAD = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_RELOAD = 2'd2
    } state_t;

    function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] l);
        return (l > LVL_MAX) ? LVL_MAX : l;
    endfunction

    // L ones packed at the LSB end, i.e. numeric value (1<<L)-1.
    function automatic logic [INPUT_SIZE-1:0] therm(input logic [LVL_W-1:0] l);
        logic [INPUT_SIZE-1:0] t;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            t[i] = (LVL_W'(i) < l);
        end
        return t;
    endfunction

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [LVL_W-1:0]      r_level  [NUM_CH];
    logic [LVL_W-1:0]      w_level_nxt  [NUM_CH];
    logic [LVL_W-1:0]      r_target [NUM_CH];
    logic [LVL_W-1:0]      w_target_nxt [NUM_CH];
    logic [NUM_CH-1:0]     r_rst, w_rst_nxt;
    logic [NUM_CH-1:0]     r_inc, w_inc_nxt;
    logic [NUM_CH-1:0]     r_dec, w_dec_nxt;
    logic [INPUT_SIZE-1:0] r_init, w_init_nxt;
    logic [CH_W-1:0]       r_rl_ch, w_rl_ch_nxt;
    logic [LVL_W-1:0]      r_rl_lvl, w_rl_lvl_nxt;

    logic                  w_accept;
    logic                  w_ch_ok;
    logic [LVL_W-1:0]      w_cmd_lvl;
    logic [NUM_CH-1:0]     w_hold;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rst_nxt    = '0;
        w_init_nxt   = r_init;
        w_rl_ch_nxt  = r_rl_ch;
        w_rl_lvl_nxt = r_rl_lvl;
        w_level_nxt  = r_level;
        w_target_nxt = r_target;
        w_inc_nxt    = '0;
        w_dec_nxt    = '0;
        w_hold       = '0;
        w_accept     = cmd_valid && (r_state == S_RUN);
        w_ch_ok      = ({1'b0, cmd_ch} < (CH_W + 1)'(NUM_CH));
        w_cmd_lvl    = clamp_lvl(cmd_level);

        // A channel being reloaded is frozen from the accepting edge until exit.
        if (r_state == S_RELOAD) begin
            w_hold[r_rl_ch] = 1'b1;
        end
        if (w_accept && (cmd_op == OP_RELOAD) && w_ch_ok) begin
            w_hold[cmd_ch] = 1'b1;
        end

        if (r_state != S_INIT) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_hold[c]) begin
                    if (r_level[c] < r_target[c]) begin
                        w_inc_nxt[c]   = 1'b1;
                        w_level_nxt[c] = r_level[c] + LVL_W'(1);
                    end else if (r_level[c] > r_target[c]) begin
                        w_dec_nxt[c]   = 1'b1;
                        w_level_nxt[c] = r_level[c] - LVL_W'(1);
                    end
                end
            end
        end

        unique case (r_state)
            S_INIT: begin
                w_rst_nxt = '1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_RUN;
                    w_rst_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_SET: begin
                            if (w_ch_ok) begin
                                w_target_nxt[cmd_ch] = w_cmd_lvl;
                            end
                        end
                        OP_CLEAR: begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                w_target_nxt[c] = '0;
                            end
                        end
                        OP_RELOAD: begin
                            if (w_ch_ok) begin
                                w_state_nxt       = S_RELOAD;
                                w_cnt_nxt         = '0;
                                w_rst_nxt[cmd_ch] = 1'b1;
                                w_init_nxt        = therm(w_cmd_lvl);
                                w_rl_ch_nxt       = cmd_ch;
                                w_rl_lvl_nxt      = w_cmd_lvl;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RELOAD: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt           = S_RUN;
                    w_cnt_nxt             = '0;
                    w_level_nxt[r_rl_ch]  = r_rl_lvl;
                    w_target_nxt[r_rl_ch] = r_rl_lvl;
                end else begin
                    w_rst_nxt[r_rl_ch] = 1'b1;
                    w_cnt_nxt          = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_rst   <= '1;
            r_init  <= '0;
            r_inc   <= '0;
            r_dec   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_level[c]  <= '0;
                r_target[c] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rst    <= w_rst_nxt;
            r_init   <= w_init_nxt;
            r_inc    <= w_inc_nxt;
            r_dec    <= w_dec_nxt;
            r_level  <= w_level_nxt;
            r_target <= w_target_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_rl_ch  <= w_rl_ch_nxt;
        r_rl_lvl <= w_rl_lvl_nxt;
    end

    assign cmd_ready = (r_state == S_RUN);
    assign ffsr_rst  = r_rst;
    assign ffsr_init = r_init;
    assign ffsr_inc  = r_inc;
    assign ffsr_dec  = r_dec;

    always_comb begin
        level   = '0;
        settled = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            level[c*LVL_W +: LVL_W] = r_level[c];
            settled[c] = (r_level[c] == r_target[c]) && !r_inc[c] && !r_dec[c];
        end
    end

endmodule

// File: tb/tb_ffsr_spike_ctrl.sv
// Bench for ffsr_spike_ctrl: each scenario queues its expected per-cycle outputs when the
// command is driven, then pops and compares one entry after every clock edge.
`timescale 1ns/1ps
module tb_ffsr_spike_ctrl;

    localparam int INPUT_SIZE = 16;
    localparam int NUM_CH     = 4;
    localparam int LVL_W      = 5;
    localparam int CH_W       = 2;

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_RELOAD = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [1:0]              cmd_op = OP_NOP;
    logic [CH_W-1:0]         cmd_ch = '0;
    logic [LVL_W-1:0]        cmd_level = '0;
    logic [NUM_CH-1:0]       ffsr_rst;
    logic [0:INPUT_SIZE-1]   ffsr_init;
    logic [NUM_CH-1:0]       ffsr_inc;
    logic [NUM_CH-1:0]       ffsr_dec;
    logic [NUM_CH*LVL_W-1:0] level;
    logic [NUM_CH-1:0]       settled;

    typedef struct packed {
        logic        rdy;
        logic [3:0]  rs;
        logic [3:0]  inc;
        logic [3:0]  dec;
        logic [19:0] lvl;
        logic [3:0]  stl;
    } snap_t;

    snap_t obs;
    assign obs = {cmd_ready, ffsr_rst, ffsr_inc, ffsr_dec, level, settled};

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    lv[4];
    int    mt[4];

    ffsr_spike_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ch    (cmd_ch),
        .cmd_level (cmd_level),
        .ffsr_rst  (ffsr_rst),
        .ffsr_init (ffsr_init),
        .ffsr_inc  (ffsr_inc),
        .ffsr_dec  (ffsr_dec),
        .level     (level),
        .settled   (settled)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [CH_W-1:0] ch,
                        input logic [LVL_W-1:0] l);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_level = l;
    endtask

    function automatic snap_t mk(logic rdy, logic [3:0] rs, logic [3:0] inc,
                                 logic [3:0] dec, logic [3:0] stl);
        snap_t s;
        s.rdy = rdy;
        s.rs  = rs;
        s.inc = inc;
        s.dec = dec;
        s.stl = stl;
        for (int c = 0; c < 4; c++) begin
            s.lvl[c*5 +: 5] = 5'(lv[c]);
        end
        return s;
    endfunction

    // Reference stepping in RUN: one level per cycle toward mt[], settled derived from it.
    function automatic snap_t model_step(bit do_step);
        logic [3:0] inc = '0;
        logic [3:0] dec = '0;
        logic [3:0] stl;
        if (do_step) begin
            for (int c = 0; c < 4; c++) begin
                if (lv[c] < mt[c]) begin
                    inc[c] = 1'b1;
                    lv[c]  = lv[c] + 1;
                end else if (lv[c] > mt[c]) begin
                    dec[c] = 1'b1;
                    lv[c]  = lv[c] - 1;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            stl[c] = (lv[c] == mt[c]) && !inc[c] && !dec[c];
        end
        return mk(1'b1, 4'h0, inc, dec, stl);
    endfunction

    task automatic test_reset();
        snap_t e;
        int    n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        lv = '{0, 0, 0, 0};
        exp_q.push_back(mk(1'b0, 4'hF, 4'h0, 4'h0, 4'hF));
        exp_q.push_back(mk(1'b0, 4'hF, 4'h0, 4'h0, 4'hF));
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        tick();
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == 0) begin
                rst = 1'b0;
                total++;
                if (ffsr_init !== 16'h0000) begin
                    bad++;
                    $display("FAIL reset_init got=%h want=%h", ffsr_init, 16'h0000);
                end
            end
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_set_basic();
        snap_t e;
        int    n;
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'b1101));
        for (int k = 1; k <= 3; k++) begin
            lv[1] = k;
            exp_q.push_back(mk(1'b1, 4'h0, 4'b0010, 4'h0, 4'b1101));
        end
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        send(OP_SET, 2'd1, 5'd3);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            cmd_valid = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL set_basic k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_clamp();
        snap_t e;
        int    n;
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'b1110));
        for (int k = 1; k <= 16; k++) begin
            lv[0] = k;
            exp_q.push_back(mk(1'b1, 4'h0, 4'b0001, 4'h0, 4'b1110));
        end
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        send(OP_SET, 2'd0, 5'd20);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            cmd_valid = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL clamp_up k=%0d got=%h want=%h", k, obs, e);
            end
        end

        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'b1110));
        for (int k = 1; k <= 14; k++) begin
            lv[0] = 16 - k;
            exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0001, 4'b1110));
        end
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        send(OP_SET, 2'd0, 5'd2);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            cmd_valid = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL clamp_down k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_reverse();
        snap_t e;
        int    n;
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'b1011));
        for (int k = 1; k <= 4; k++) begin
            lv[2] = k;
            exp_q.push_back(mk(1'b1, 4'h0, 4'b0100, 4'h0, 4'b1011));
        end
        for (int k = 5; k <= 8; k++) begin
            lv[2] = 8 - k;
            exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'b0100, 4'b1011));
        end
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        send(OP_SET, 2'd2, 5'd10);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == 3) begin
                send(OP_SET, 2'd2, 5'd0);
            end else begin
                cmd_valid = 1'b0;
            end
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reverse k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_reload();
        snap_t e;
        int    n;
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'b1101));
        lv[1] = 4;
        exp_q.push_back(mk(1'b1, 4'h0, 4'b0010, 4'h0, 4'b1101));
        lv[1] = 5;
        exp_q.push_back(mk(1'b0, 4'b1000, 4'b0010, 4'h0, 4'b1101));
        lv[1] = 6;
        exp_q.push_back(mk(1'b0, 4'b1000, 4'b0010, 4'h0, 4'b1101));
        lv[1] = 7; lv[3] = 4;
        exp_q.push_back(mk(1'b1, 4'h0, 4'b0010, 4'h0, 4'b1101));
        lv[1] = 8;
        exp_q.push_back(mk(1'b1, 4'h0, 4'b0010, 4'h0, 4'b1100));
        lv[0] = 3; lv[1] = 9;
        exp_q.push_back(mk(1'b1, 4'h0, 4'b0011, 4'h0, 4'b1100));
        lv[0] = 4; lv[1] = 10;
        exp_q.push_back(mk(1'b1, 4'h0, 4'b0011, 4'h0, 4'b1100));
        lv[0] = 5;
        exp_q.push_back(mk(1'b1, 4'h0, 4'b0001, 4'h0, 4'b1110));
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        send(OP_SET, 2'd1, 5'd10);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == 1) begin
                send(OP_RELOAD, 2'd3, 5'd4);
            end else if (k == 2) begin
                send(OP_SET, 2'd0, 5'd5);
            end else if (k == 0 || k >= 5) begin
                cmd_valid = 1'b0;
            end
            if (k == 2 || k == 4) begin
                total++;
                if (ffsr_init !== 16'h000F) begin
                    bad++;
                    $display("FAIL reload_init k=%0d got=%h want=%h", k, ffsr_init, 16'h000F);
                end
            end
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reload k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_reload();
        snap_t e;
        int    n;
        exp_q.push_back(mk(1'b0, 4'b0100, 4'h0, 4'h0, 4'hF));
        lv = '{0, 0, 0, 0};
        exp_q.push_back(mk(1'b0, 4'hF, 4'h0, 4'h0, 4'hF));
        exp_q.push_back(mk(1'b0, 4'hF, 4'h0, 4'h0, 4'hF));
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF));
        send(OP_RELOAD, 2'd2, 5'd7);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == 0) begin
                cmd_valid = 1'b0;
                rst = 1'b1;
                total++;
                if (ffsr_init !== 16'h007F) begin
                    bad++;
                    $display("FAIL midrst_init0 got=%h want=%h", ffsr_init, 16'h007F);
                end
            end else if (k == 1) begin
                rst = 1'b0;
                total++;
                if (ffsr_init !== 16'h0000) begin
                    bad++;
                    $display("FAIL midrst_init1 got=%h want=%h", ffsr_init, 16'h0000);
                end
            end
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid_reload k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_clear_nop();
        snap_t e;
        int    n;
        mt = '{0, 0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(model_step(1'b1));
        end
        send(OP_NOP, 2'd2, 5'd9);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            cmd_valid = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL nop k=%0d got=%h want=%h", k, obs, e);
            end
        end

        mt[2] = 9;
        exp_q.push_back(model_step(1'b0));
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(model_step(1'b1));
        end
        send(OP_SET, 2'd2, 5'd9);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            cmd_valid = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL clear_setup k=%0d got=%h want=%h", k, obs, e);
            end
        end

        mt = '{0, 0, 0, 0};
        exp_q.push_back(model_step(1'b0));
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(model_step(1'b1));
        end
        send(OP_CLEAR, 2'd1, 5'd12);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            cmd_valid = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL clear_all k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_basic();
        test_clamp();
        test_reverse();
        test_reload();
        test_reset_mid_reload();
        test_clear_nop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
